// File: rtl/e_mult_div_unit_if.sv
// E-stage multiply/divide request/response bundle: operands, decoded op and flush in;
// busy, HI/LO and MFHI/MFLO read data out.
interface e_mult_div_unit_if;
  logic        start;
  logic [3:0]  op;
  logic        flush;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        rd_hi;
  logic        busy;
  logic [31:0] mdout;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, flush, srcA, srcB, rd_hi,
    input  busy, mdout, hi, lo
  );

  modport slave (
    input  start, op, flush, srcA, srcB, rd_hi,
    output busy, mdout, hi, lo
  );
endinterface

// File: rtl/e_mult_div_unit.sv
// MULT/DIV unit with architectural HI/LO: mul/div hold busy for MULT_CYCLES/DIV_CYCLES, MTHI/MTLO write at once;
// starts while busy are dropped (hazard unit stalls on busy). MDU_MADD_EN adds MADD/MADDU accumulate.
module e_mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  e_mult_div_unit_if.slave md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif
  localparam logic [3:0] MUL_LAT  = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept, is_mul, is_div, div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, uq, ur, quo, rem;

  assign accept = md.start && !md.flush && (state_q == S_IDLE);

  always_comb begin
    is_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (md.op == OP_MADD) || (md.op == OP_MADDU);
`endif
    is_div = (md.op == OP_DIV) || (md.op == OP_DIVU);
  end

  // Results use only the latched operands, never the live E-stage buses.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps cleanly to 0x80000000 rem 0.
  assign div_signed = (op_q == OP_DIV);
  assign a_mag = (div_signed && a_q[31]) ? -a_q : a_q;
  assign b_mag = (div_signed && b_q[31]) ? -b_q : b_q;
  assign uq    = a_mag / b_mag;
  assign ur    = a_mag % b_mag;
  assign quo   = (div_signed && (a_q[31] ^ b_q[31])) ? -uq : uq;
  assign rem   = (div_signed && a_q[31]) ? -ur : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            state_d = S_BUSY;
            cnt_d   = is_div ? DIV_LAT : MUL_LAT;
            op_d    = md.op;
            a_d     = md.srcA;
            b_d     = md.srcB;
          end else if (md.op == OP_MTHI) begin
            hi_d = md.srcA;
          end else if (md.op == OP_MTLO) begin
            lo_d = md.srcA;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
            OP_DIV, OP_DIVU: begin
              // Divide by zero spends the full latency but leaves HI/LO alone.
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quo;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md.busy  = (state_q == S_BUSY);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.mdout = md.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Scoreboard bench for e_mult_div_unit: a driver issues ops and queues expected HI/LO/busy length,
// a negedge monitor compares when each op is due. Define MDU_MADD_EN to exercise MADD/MADDU.
module tb_e_mult_div_unit;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  e_mult_div_unit_if md();

  e_mult_div_unit #(.MULT_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          tests = 0;
  int          fails = 0;
  int          run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural reference: plain 64-bit integer arithmetic on the ISA rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    lat = 0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sbv); {m_hi, m_lo} = p; lat = MUL_LAT; end
      OP_MULTU: begin p = 64'(ua * ub);  {m_hi, m_lo} = p; lat = MUL_LAT; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin p = {m_hi, m_lo} + 64'(sa * sbv); {m_hi, m_lo} = p; lat = MUL_LAT; end
      OP_MADDU: begin p = {m_hi, m_lo} + 64'(ua * ub);  {m_hi, m_lo} = p; lat = MUL_LAT; end
`endif
      OP_DIV: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin
          q = sa / sbv;
          r = sa % sbv;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin
          m_lo = 32'(ua / ub);
          m_hi = 32'(ua % ub);
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic push_expect(input int lat, input int due);
    exp_t e;
    e.lat = lat;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Drive one op; while the unit is busy, throw ignored starts/flushes at it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    int lat;
    md.start = 1'b1;
    md.op    = op;
    md.srcA  = a;
    md.srcB  = b;
    md.flush = fl;
    md.rd_hi = 1'($urandom);
    lat = 0;
    if (!fl) model(op, a, b, lat);
    push_expect(lat, cyc + 1 + lat);
    @(posedge clk);
    #1;
    for (int i = 0; i < lat; i++) begin
      md.start = 1'($urandom);
      md.op    = 4'($urandom_range(0, 15));
      md.srcA  = $urandom;
      md.srcB  = $urandom;
      md.flush = (i == 2) ? 1'b1 : 1'($urandom);
      md.rd_hi = 1'($urandom);
      @(posedge clk);
      #1;
    end
    md.start = 1'b0;
    md.flush = 1'b0;
    drain();
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles and compares the queue head once it is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else begin
        if (md.busy) run++;
        if (sb.size() > 0 && cyc >= sb[0].due) begin
          e = sb.pop_front();
          check("busy_cycles", 32'(run), 32'(e.lat));
          run = 0;
          check("busy_clear", {31'd0, md.busy}, 32'd0);
          check("hi", md.hi, e.hi);
          check("lo", md.lo, e.lo);
          check("mdout", md.mdout, md.rd_hi ? e.hi : e.lo);
        end
      end
    end
  end

  initial begin
    md.start = 1'b0;
    md.op    = OP_NONE;
    md.flush = 1'b0;
    md.srcA  = 32'd0;
    md.srcB  = 32'd0;
    md.rd_hi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    push_expect(0, cyc);
    drain();

    issue(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(OP_MTHI, 32'h11, 32'd0, 1'b0);
    issue(OP_MTLO, 32'h22, 32'd0, 1'b0);
    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(OP_MTLO, 32'h1234, 32'd0, 1'b1);
    issue(OP_MULT, 32'd5, 32'd6, 1'b1);
    issue(OP_MULT, 32'd1000, 32'hFFFF_FFFE, 1'b0);

    // Reset during the third busy cycle of a DIV abandons it.
    issue(OP_MTHI, 32'hAAAA, 32'd0, 1'b0);
    issue(OP_MTLO, 32'h5555, 32'd0, 1'b0);
    md.start = 1'b1;
    md.op    = OP_DIV;
    md.srcA  = 32'd77;
    md.srcB  = 32'd5;
    @(posedge clk);
    #1;
    md.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    push_expect(0, cyc);
    drain();
    repeat (12) begin @(posedge clk); #1; end
    issue(OP_NONE, 32'd0, 32'd0, 1'b0);

    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(OP_MULT, 32'd7, 32'd9, 1'b0);

    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    issue(OP_MADD, 32'hFFFF_FFFF, 32'd3, 1'b0);

    for (int t = 0; t < 200; t++) begin
      issue(4'($urandom_range(0, 10)), rnd_val(), rnd_val(), ($urandom_range(0, 5) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
